alu_issue_ctrl: RTL and testbench

Multi-cycle issue/decode unit that drives the datapath ALU (X, Y, 4-bit CONTROL in; RESULT and ZERO out).
- Accepts one RV32I instruction per handshake and decodes opcode/funct3/funct7 into the ALU control code.
- Selects and registers the operands, then captures RESULT/ZERO.
- Emits either a register writeback or a branch decision.
- Sits between the fetch/register-file stage and the ALU; it is the initiator side of the ALU interface.

---
 rtl/alu_issue_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : 4-cycle RV32I issue/decode unit driving an external ALU; emits
//            a register writeback, a branch decision or an illegal pulse.
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            br_valid,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            illegal
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_RESP} state_t;

  localparam logic [1:0] c_k_wb  = 2'd0;
  localparam logic [1:0] c_k_br  = 2'd1;
  localparam logic [1:0] c_k_ill = 2'd2;

  state_t          r_state;
  logic            r_ready;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc, r_rs1, r_rs2, r_res;
  logic            r_zero, r_inv;
  logic [1:0]      r_kind;
  logic [XLEN-1:0] r_alu_x, r_alu_y, r_wb_data, r_br_target;
  logic [3:0]      r_alu_ctrl;
  logic            r_wb_valid, r_wb_we, r_br_valid, r_br_taken, r_ill;
  logic [4:0]      r_wb_rd;

  logic [6:0]      w_op, w_f7;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_imm_i, w_imm_u, w_imm_b, w_shamt, w_x, w_y;
  logic [3:0]      w_ctrl;
  logic [1:0]      w_kind;
  logic            w_inv;
  logic            w_unused_ok;

  assign w_op        = r_instr[6:0];
  assign w_f3        = r_instr[14:12];
  assign w_f7        = r_instr[31:25];
  assign w_imm_i     = XLEN'(signed'(r_instr[31:20]));
  assign w_imm_u     = XLEN'(signed'({r_instr[31:12], 12'b0}));
  assign w_imm_b     = XLEN'(signed'({r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0}));
  assign w_shamt     = XLEN'(r_instr[24:20]);
  assign w_unused_ok = ^r_instr[19:15];

  // Shared funct3 -> ALU code map for the non-arith/shift-variant cases.
  function automatic logic [3:0] f3code(input logic [2:0] f3);
    case (f3)
      3'b001:  f3code = 4'b1000;
      3'b010:  f3code = 4'b0100;
      3'b011:  f3code = 4'b1101;
      3'b100:  f3code = 4'b1001;
      3'b110:  f3code = 4'b0001;
      3'b111:  f3code = 4'b0010;
      default: f3code = 4'b0000;
    endcase
  endfunction

  always_comb begin
    w_x    = r_rs1;
    w_y    = r_rs2;
    w_ctrl = 4'b0000;
    w_kind = c_k_ill;
    w_inv  = 1'b0;
    case (w_op)
      7'b0110011: begin
        case (w_f3)
          3'b000: begin
            if (w_f7 == 7'b0000000) begin w_ctrl = 4'b0000; w_kind = c_k_wb; end
            else if (w_f7 == 7'b0100000) begin w_ctrl = 4'b0111; w_kind = c_k_wb; end
          end
          3'b101: begin
            if (w_f7 == 7'b0000000) begin w_ctrl = 4'b1010; w_kind = c_k_wb; end
            else if (w_f7 == 7'b0100000) begin w_ctrl = 4'b1110; w_kind = c_k_wb; end
          end
          default: if (w_f7 == 7'b0000000) begin w_ctrl = f3code(w_f3); w_kind = c_k_wb; end
        endcase
      end
      7'b0010011: begin
        w_y = w_imm_i;
        case (w_f3)
          3'b000: begin w_ctrl = 4'b0000; w_kind = c_k_wb; end
          3'b001: begin
            w_y = w_shamt;
            if (w_f7 == 7'b0000000) begin w_ctrl = 4'b1000; w_kind = c_k_wb; end
          end
          3'b101: begin
            w_y = w_shamt;
            if (w_f7 == 7'b0000000) begin w_ctrl = 4'b1010; w_kind = c_k_wb; end
            else if (w_f7 == 7'b0100000) begin w_ctrl = 4'b1110; w_kind = c_k_wb; end
          end
          default: begin w_ctrl = f3code(w_f3); w_kind = c_k_wb; end
        endcase
      end
      7'b0110111: begin w_x = '0;   w_y = w_imm_u; w_ctrl = 4'b1100; w_kind = c_k_wb; end
      7'b0010111: begin w_x = r_pc; w_y = w_imm_u; w_ctrl = 4'b0000; w_kind = c_k_wb; end
      7'b1100011: begin
        w_kind = c_k_br;
        case (w_f3)
          3'b000:  w_ctrl = 4'b1111;
          3'b001:  w_ctrl = 4'b0011;
          3'b100:  w_ctrl = 4'b0100;
          3'b101:  begin w_ctrl = 4'b0100; w_inv = 1'b1; end
          3'b110:  w_ctrl = 4'b1101;
          3'b111:  begin w_ctrl = 4'b1101; w_inv = 1'b1; end
          default: w_kind = c_k_ill;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_instr     <= '0;
      r_pc        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_res       <= '0;
      r_zero      <= 1'b0;
      r_inv       <= 1'b0;
      r_kind      <= c_k_ill;
      r_alu_x     <= '0;
      r_alu_y     <= '0;
      r_alu_ctrl  <= 4'b0000;
      r_br_target <= '0;
      r_wb_data   <= '0;
      r_wb_rd     <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_br_valid  <= 1'b0;
      r_br_taken  <= 1'b0;
      r_ill       <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_br_valid <= 1'b0;
      r_ill      <= 1'b0;
      case (r_state)
        S_IDLE: if (instr_valid) begin
          r_instr <= instr;
          r_pc    <= pc;
          r_rs1   <= rs1_data;
          r_rs2   <= rs2_data;
          r_ready <= 1'b0;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_alu_x     <= w_x;
          r_alu_y     <= w_y;
          r_alu_ctrl  <= w_ctrl;
          r_br_target <= r_pc + w_imm_b;
          r_kind      <= w_kind;
          r_inv       <= w_inv;
          r_state     <= S_EXEC;
        end
        S_EXEC: begin
          r_res   <= alu_result;
          r_zero  <= alu_zero;
          r_state <= S_RESP;
        end
        default: begin
          // Response pulses register on the edge leaving RESP.
          if (r_kind == c_k_wb) begin
            r_wb_valid <= 1'b1;
            r_wb_we    <= (r_instr[11:7] != 5'd0);
            r_wb_rd    <= r_instr[11:7];
            r_wb_data  <= r_res;
          end else if (r_kind == c_k_br) begin
            r_br_valid <= 1'b1;
            r_br_taken <= r_zero ^ r_inv;
          end else begin
            r_ill <= 1'b1;
          end
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign alu_x       = r_alu_x;
  assign alu_y       = r_alu_y;
  assign alu_control = r_alu_ctrl;
  assign wb_valid    = r_wb_valid;
  assign wb_we       = r_wb_we;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
  assign br_valid    = r_br_valid;
  assign br_taken    = r_br_taken;
  assign br_target   = r_br_target;
  assign illegal     = r_ill;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Vector-table bench for alu_issue_ctrl with a behavioural ALU.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [31:0] alu_x, alu_y, alu_result, wb_data, br_target;
  logic [3:0]  alu_control;
  logic        alu_zero, wb_valid, wb_we, br_valid, br_taken, illegal;
  logic [4:0]  wb_rd;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_x(alu_x), .alu_y(alu_y), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target), .illegal(illegal)
  );

  // ALU model; zero flag is set when the result is nonzero.
  always_comb begin
    alu_result = 32'd0;
    case (alu_control)
      4'b0000: alu_result = alu_x + alu_y;
      4'b0111: alu_result = alu_x - alu_y;
      4'b1000: alu_result = alu_x << alu_y[4:0];
      4'b0100: alu_result = {31'd0, $signed(alu_x) < $signed(alu_y)};
      4'b1101: alu_result = {31'd0, alu_x < alu_y};
      4'b1001: alu_result = alu_x ^ alu_y;
      4'b1010: alu_result = alu_x >> alu_y[4:0];
      4'b1110: alu_result = $unsigned($signed(alu_x) >>> alu_y[4:0]);
      4'b0001: alu_result = alu_x | alu_y;
      4'b0010: alu_result = alu_x & alu_y;
      4'b1100: alu_result = alu_y;
      4'b1111: alu_result = {31'd0, alu_x == alu_y};
      4'b0011: alu_result = {31'd0, alu_x != alu_y};
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_zero = (alu_result != 32'd0);

  typedef struct {
    string       name;
    logic [31:0] instr, pc, rs1, rs2;
    logic [3:0]  ctrl;
    logic        chk_x;
    logic [31:0] x, y;
    logic [2:0]  pulses;   // {wb_valid, br_valid, illegal}
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        taken;
    logic [31:0] target;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    int t;
    @(negedge clk);
    instr = i; pc = p; rs1_data = a; rs2_data = b; instr_valid = 1'b1;
    t = 0;
    while (!instr_ready && t < 10) begin @(negedge clk); t++; end
    if (!instr_ready) check("handshake_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    start(v.instr, v.pc, v.rs1, v.rs2);
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check({v.name, "_ctrl"}, {28'd0, alu_control}, {28'd0, v.ctrl});
    if (v.chk_x) check({v.name, "_x"}, alu_x, v.x);
    check({v.name, "_y"}, alu_y, v.y);
    check({v.name, "_ready_exec"}, {31'd0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    check({v.name, "_quiet_resp"}, {29'd0, wb_valid, br_valid, illegal}, 32'd0);
    @(posedge clk); #1;
    check({v.name, "_pulses"}, {29'd0, wb_valid, br_valid, illegal}, {29'd0, v.pulses});
    check({v.name, "_ready_after"}, {31'd0, instr_ready}, 32'd1);
    if (v.pulses[2]) begin
      check({v.name, "_we"}, {31'd0, wb_we}, {31'd0, v.we});
      check({v.name, "_rd"}, {27'd0, wb_rd}, {27'd0, v.rd});
      check({v.name, "_data"}, wb_data, v.data);
    end
    if (v.pulses[1]) begin
      check({v.name, "_taken"}, {31'd0, br_taken}, {31'd0, v.taken});
      check({v.name, "_target"}, br_target, v.target);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          name     instr         pc          rs1          rs2         ctrl   cx  x            y            pls    we  rd  data         tk  target
    vecs[0]  = '{"sub",   32'h402082B3, 32'h0,     32'd10,      32'd3,      4'b0111, 1, 32'd10,      32'd3,       3'b100, 1, 5,  32'd7,       0, 32'h0};
    vecs[1]  = '{"srai0", 32'h4040D013, 32'h0,     32'h80000000, 32'h0,     4'b1110, 1, 32'h80000000, 32'd4,      3'b100, 0, 0,  32'hF8000000, 0, 32'h0};
    vecs[2]  = '{"bge_nt",32'h0020D463, 32'h100,   32'hFFFFFFFF, 32'd1,     4'b0100, 1, 32'hFFFFFFFF, 32'd1,      3'b010, 0, 0,  32'h0,       0, 32'h108};
    vecs[3]  = '{"ill_op",32'h0000007F, 32'h0,     32'd1,       32'd2,      4'b0000, 0, 32'h0,       32'd2,       3'b001, 0, 0,  32'h0,       0, 32'h0};
    vecs[4]  = '{"beq_t", 32'h00208463, 32'h200,   32'd5,       32'd5,      4'b1111, 1, 32'd5,       32'd5,       3'b010, 0, 0,  32'h0,       1, 32'h208};
    vecs[5]  = '{"addi",  32'hFFF08193, 32'h0,     32'd10,      32'd0,      4'b0000, 1, 32'd10,      32'hFFFFFFFF, 3'b100, 1, 3,  32'd9,       0, 32'h0};
    vecs[6]  = '{"lui",   32'h123453B7, 32'h0,     32'd7,       32'd0,      4'b1100, 0, 32'h0,       32'h12345000, 3'b100, 1, 7,  32'h12345000, 0, 32'h0};
    vecs[7]  = '{"auipc", 32'h00001097, 32'h400,   32'd0,       32'd0,      4'b0000, 1, 32'h400,     32'h1000,    3'b100, 1, 1,  32'h1400,    0, 32'h0};
    vecs[8]  = '{"ill_f7",32'h02208033, 32'h0,     32'd1,       32'd2,      4'b0000, 0, 32'h0,       32'd2,       3'b001, 0, 0,  32'h0,       0, 32'h0};
    vecs[9]  = '{"ill_br",32'h0020A463, 32'h0,     32'd1,       32'd2,      4'b0000, 0, 32'h0,       32'd2,       3'b001, 0, 0,  32'h0,       0, 32'h0};
    vecs[10] = '{"bne_wr",32'hFE209EE3, 32'h0,     32'd1,       32'd2,      4'b0011, 1, 32'd1,       32'd2,       3'b010, 0, 0,  32'h0,       1, 32'hFFFFFFFC};
    vecs[11] = '{"bgeu_t",32'h0020F463, 32'h10,    32'd5,       32'd3,      4'b1101, 1, 32'd5,       32'd3,       3'b010, 0, 0,  32'h0,       1, 32'h18};
    vecs[12] = '{"slli",  32'h00309213, 32'h0,     32'd1,       32'd0,      4'b1000, 1, 32'd1,       32'd3,       3'b100, 1, 4,  32'd8,       0, 32'h0};

    // Reset held two cycles with a pending instruction.
    rst_n = 1'b0; instr_valid = 1'b1; instr = 32'h402082B3; pc = 0; rs1_data = 10; rs2_data = 3;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_pulses", {28'd0, wb_valid, br_valid, illegal, wb_we}, 32'd0);
    check("rst_ctrl", {28'd0, alu_control}, 32'd0);
    check("rst_x", alu_x, 32'd0);
    check("rst_target", br_target, 32'd0);
    instr_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Back-to-back: valid held high, second accept in the IDLE cycle after RESP.
    start(32'h402082B3, 32'h0, 32'd20, 32'd6);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_wb1", {31'd0, wb_valid}, 32'd1);
    check("b2b_data1", wb_data, 32'd14);
    check("b2b_ready_idle", {31'd0, instr_ready}, 32'd1);
    rs1_data = 32'd50;
    @(posedge clk); #1;
    check("b2b_accept2", {31'd0, instr_ready}, 32'd0);
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_wb2", {31'd0, wb_valid}, 32'd1);
    check("b2b_data2", wb_data, 32'd44);

    // Reset asserted while in EXEC discards the instruction silently.
    start(32'h402082B3, 32'h0, 32'd9, 32'd1);
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    check("mid_rst_x", alu_x, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("mid_rst_no_pulse", {29'd0, wb_valid, br_valid, illegal}, 32'd0);
      check("mid_rst_ready_hold", {31'd0, instr_ready}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
